sfq_toggle_deserializer: RTL and testbench
==========================================

// Module: sfq_toggle_deserializer
// PURPOSE
// - Clocked receiver at the output end of the DFFT toggle-pulse path: every level transition on sfq_in is one SFQ pulse.
// - Samples the toggle stream in fixed bit slots: a toggle inside a slot decodes as 1, no toggle as 0.
// - Packs the decoded bits LSB-first into WIDTH-bit words and presents them on a valid/ready interface.
// - Flags double pulses within one slot (the receive-side counterpart of the cell critical-timing check) and word overruns.
// PARAMETERS
// - WIDTH        8   bits per word, >=2
// - SLOT_CYCLES  4   clk cycles per bit slot, >=2
// - SYNC_STAGES  2   synchronizer flops on sfq_in, >=2
// PORTS
// - clk        in   1      sole clock; all logic on its rising edge
// - rst        in   1      synchronous, active-high reset
// - sfq_in     in   1      asynchronous toggle-encoded pulse stream from the DFFT q output
// - run        in   1      level; high = decode continuous words, low = stop at the next word boundary
// - out_data   out  WIDTH  decoded word; bit 0 = first slot
// - out_valid  out  1      word held on out_data
// - out_ready  in   1      consumer accepts the word when out_valid && out_ready
// - viol_err   out  1      sticky: >=2 toggles seen in one slot
// - ovr_err    out  1      sticky: word completed while the previous word was still unaccepted
// - clr_err    in   1      synchronous clear of all sticky error flags
// BEHAVIOUR
// - Reset: state=IDLE; slot/bit counters=0; shift reg=0; out_data=0; out_valid=0; viol_err=0; ovr_err=0; sync flops=0.
// - Toggle detect: tog = sync[last] ^ sync[last-1] after SYNC_STAGES flops; tog is one clk cycle per input edge.
// - The sync chain runs in all states; the detect-reference flop is reloaded on IDLE->SHIFT so stale edges are not counted.
// - FSM IDLE: counters held at 0; tog is ignored. Goes to SHIFT on the first cycle run=1.
// - FSM SHIFT: slot_cnt counts 0..SLOT_CYCLES-1 and a per-slot toggle count saturates at 2.
// - End of slot (slot_cnt==SLOT_CYCLES-1): bit = (count>=1), shifted in at bit_cnt; count>=2 sets viol_err and the bit stays 1.
// - A tog arriving in the final cycle of a slot counts toward that slot.
// - End of word (bit_cnt==WIDTH-1 at end of slot): the word is loaded into out_data and out_valid=1 on the next cycle.
// - Total latency is 1 cycle after the last slot plus sync delay.
// - If out_valid=1 and the handshake has not fired in the load cycle: ovr_err=1 and the new word is dropped; out_data is unchanged.
// - A handshake in the same cycle as a load counts as accepted, so the new word loads with no overrun.
// - After a word: stay in SHIFT with counters reset if run=1, else go to IDLE. Deasserting run mid-word always finishes the word.
// - out_valid drops the cycle after the handshake unless a new word loads in that same cycle.
// - clr_err has priority over a same-cycle error set: flags read 0 the next cycle.
// - rst mid-word discards the partial word and any held output word; the first tog after reset is not decoded unless in SHIFT.
// CONFIGURATION
// - Macro SFQ_RX_PARITY_EN defined:
//   - Each word carries one extra slot after bit WIDTH-1, containing even parity over the data bits.
//   - An added output par_err (sticky, cleared by rst/clr_err) is set when the parity slot mismatches.
//   - A mismatched word is still delivered. Word period = (WIDTH+1)*SLOT_CYCLES.
// - Macro undefined: no parity slot, no par_err port; word period = WIDTH*SLOT_CYCLES.
// STRUCTURE
// - Package sfq_rx_pkg holds:
//   - state enum {IDLE, SHIFT}
//   - localparam helpers for counter widths ($clog2 of SLOT_CYCLES and WIDTH+1)
//   - toggle-count saturation constant TOG_SAT=2
// - Sub-module sfq_edge_sync: SYNC_STAGES flop chain plus a detect-reference flop with a reload input; output tog.
// - The top level holds the FSM, counters, shift register, output register and error flags.
// TESTING
// - T1 (WIDTH=8, SLOT_CYCLES=4): run=1, out_ready=1, toggles in slots 0,2,7 -> out_data=8'h85, out_valid for one cycle, no errors.
// - T2: two toggles 2 cycles apart inside slot 3, other slots empty -> out_data=8'h08, viol_err=1 until clr_err; clr_err -> 0 next cycle.
// - T3: out_ready=0, two words 8'hFF then 8'h01 -> out_data stays 8'hFF, ovr_err=1; out_ready=1 -> handshake, out_valid drops next cycle.
// - T4: deassert run at bit 4 of a word toggling every slot -> word completes as 8'hFF, then IDLE; toggles in IDLE produce no output.
// - T5: assert rst at bit 5 mid-word with out_valid=1 -> next cycle all outputs 0, state IDLE; run=1 restarts a clean word.
// - T6 (SFQ_RX_PARITY_EN): data 8'h03 with parity slot toggled (wrong) -> word 8'h03 delivered and par_err=1; correct parity -> par_err stays 0.

Source files
------------

// File: rtl/sfq_rx_pkg.sv
// Shared types and constants for the SFQ toggle-stream deserializer.
package sfq_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int TOG_SAT = 2;
  localparam int TOG_W   = $clog2(TOG_SAT + 1);

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sfq_edge_sync.sv
// Synchronizer chain for the asynchronous toggle line plus an edge-detect reference flop.
// The reference only follows the chain while tracking; i_reload realigns it before decoding starts.
module sfq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  input  logic i_track,
  input  logic i_reload,
  output logic o_tog
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ref;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_ref  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      if (i_track || i_reload) r_ref <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_tog = r_sync[SYNC_STAGES-1] ^ r_ref;

endmodule

// File: rtl/sfq_toggle_deserializer.sv
// Slot-based decoder for a DFFT toggle-pulse stream, packing bits LSB-first into words.
// Define SFQ_RX_PARITY_EN to add an even-parity slot per word and the par_err flag.
module sfq_toggle_deserializer
  import sfq_rx_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SLOT_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sfq_in,
  input  logic             run,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             viol_err,
  output logic             ovr_err,
`ifdef SFQ_RX_PARITY_EN
  output logic             par_err,
`endif
  input  logic             clr_err
);

`ifdef SFQ_RX_PARITY_EN
  localparam int NSLOTS = WIDTH + 1;
`else
  localparam int NSLOTS = WIDTH;
`endif
  localparam int SLOT_W = cnt_w(SLOT_CYCLES);
  localparam int BIT_W  = cnt_w(WIDTH + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NSLOTS - 1);
  localparam logic [TOG_W-1:0]  TOG_MAX   = TOG_W'(TOG_SAT);

  state_e            r_state, w_state_nxt;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [TOG_W-1:0]  r_tog_cnt, w_tog_sum;
  logic [WIDTH-1:0]  r_shift, w_word;
  logic w_tog, w_tog_in, w_reload, w_shift_en;
  logic w_slot_end, w_word_end, w_bit, w_viol, w_load, w_ovr;

  sfq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (sfq_in),
    .i_track (w_shift_en),
    .i_reload(w_reload),
    .o_tog   (w_tog)
  );

  assign w_shift_en = (r_state == SHIFT);
  assign w_tog_in   = w_tog & w_shift_en;
  assign w_slot_end = w_shift_en && (r_slot_cnt == SLOT_LAST);
  assign w_word_end = w_slot_end && (r_bit_cnt == BIT_LAST);
  assign w_bit      = (w_tog_sum != '0);
  assign w_viol     = w_slot_end && (w_tog_sum >= TOG_MAX);
  // A handshake in the load cycle frees the output register for the new word.
  assign w_ovr      = w_word_end && out_valid && !out_ready;
  assign w_load     = w_word_end && !w_ovr;

  always_comb begin
    w_tog_sum = r_tog_cnt;
    if (r_tog_cnt < TOG_MAX) w_tog_sum = r_tog_cnt + TOG_W'(w_tog_in);
  end

  always_comb begin
    w_word = r_shift;
`ifndef SFQ_RX_PARITY_EN
    w_word[WIDTH-1] = w_bit;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_reload    = 1'b0;
    case (r_state)
      IDLE: begin
        if (run) begin
          w_state_nxt = SHIFT;
          w_reload    = 1'b1;
        end
      end
      SHIFT: begin
        if (w_word_end && !run) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_slot_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tog_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_shift_en) begin
        r_slot_cnt <= '0;
        r_bit_cnt  <= '0;
        r_tog_cnt  <= '0;
      end else if (w_slot_end) begin
        r_slot_cnt <= '0;
        r_tog_cnt  <= '0;
        if (w_word_end) begin
          r_bit_cnt <= '0;
          r_shift   <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          for (int i = 0; i < WIDTH; i++) begin
            if (r_bit_cnt == BIT_W'(i)) r_shift[i] <= w_bit;
          end
        end
      end else begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
        r_tog_cnt  <= w_tog_sum;
      end
    end
  end

  // Output register and sticky flags; clr_err wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      viol_err  <= 1'b0;
      ovr_err   <= 1'b0;
`ifdef SFQ_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        out_data  <= w_word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clr_err) begin
        viol_err <= 1'b0;
        ovr_err  <= 1'b0;
`ifdef SFQ_RX_PARITY_EN
        par_err  <= 1'b0;
`endif
      end else begin
        if (w_viol) viol_err <= 1'b1;
        if (w_ovr)  ovr_err  <= 1'b1;
`ifdef SFQ_RX_PARITY_EN
        if (w_word_end && (w_bit != ^r_shift)) par_err <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sfq_toggle_deserializer.sv
// Scoreboard bench: words are turned into timed toggle schedules, expected words are queued,
// and a monitor compares every handshaken word against the queue.
module tb_sfq_toggle_deserializer;

  localparam int W  = 8;
  localparam int SC = 4;
  localparam int SS = 2;
`ifdef SFQ_RX_PARITY_EN
  localparam int NSL = W + 1;
`else
  localparam int NSL = W;
`endif
  localparam int P    = NSL * SC;
  localparam int MAXW = 6;
  localparam int MAXN = MAXW * P + 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sfq_in = 1'b0;
  logic         run = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         viol_err;
  logic         ovr_err;
  logic         clr_err = 1'b0;
`ifdef SFQ_RX_PARITY_EN
  logic         par_err;
`endif

  sfq_toggle_deserializer #(.WIDTH(W), .SLOT_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst      (rst),
    .sfq_in   (sfq_in),
    .run      (run),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .viol_err (viol_err),
    .ovr_err  (ovr_err),
`ifdef SFQ_RX_PARITY_EN
    .par_err  (par_err),
`endif
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  logic [W-1:0] dq[$];

  logic [W-1:0] bw_data [MAXW];
  int           bw_vslot[MAXW];
  bit           bw_push [MAXW];
  bit           bw_pbad [MAXW];
  bit           sched   [MAXN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (dq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_word: got=%0h required=no word at %0t", out_data, $time);
      end else begin
        check("word", out_data, dq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic set_word(input int w, input logic [W-1:0] d, input int vslot,
                          input bit push, input bit pbad);
    bw_data[w]  = d;
    bw_vslot[w] = vslot;
    if (vslot >= 0 && vslot < W) bw_data[w][vslot] = 1'b1;
    bw_push[w]  = push;
    bw_pbad[w]  = pbad;
  endtask

  // Slot s of word w spans stream cycles; a toggle driven in cycle n is seen by the decoder in cycle n+2.
  task automatic build(input int nw);
    int  base, j;
    bit  b;
    for (int n = 0; n < MAXN; n++) sched[n] = 1'b0;
    for (int w = 0; w < nw; w++) begin
      for (int s = 0; s < NSL; s++) begin
        if (s < W) b = bw_data[w][s];
        else       b = (^bw_data[w]) ^ bw_pbad[w];
        if (b) begin
          base = w * P + s * SC;
          if (s == bw_vslot[w]) begin
            if (base == 0) begin sched[0] = 1'b1; sched[1] = 1'b1; end
            else begin sched[base-1] = 1'b1; sched[base+1] = 1'b1; end
          end else begin
            if (base == 0) j = int'($urandom_range(1, 0));
            else           j = int'($urandom_range(3, 0)) - 2;
            sched[base+j] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic burst(input int nw, input int run_off, input int rst_at);
    bit aborted = 1'b0;
    build(nw);
    for (int w = 0; w < nw; w++) if (bw_push[w]) dq.push_back(bw_data[w]);
    repeat (5) @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < nw * P; n++) begin
      if (n == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (sched[n]) sfq_in = ~sfq_in;
      if (n == run_off) run = 1'b0;
      @(posedge clk); #1;
    end
    if (!aborted) begin
      run = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    int  nw;
    bit  ev, ep;
    logic [W-1:0] rd;
    for (int w = 0; w < MAXW; w++) set_word(w, '0, -1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_viol", viol_err, 0);
    check("rst_ovr", ovr_err, 0);

    // T1
    set_word(0, 8'h85, -1, 1'b1, 1'b0);
    burst(1, 1, -1);
    check("t1_viol", viol_err, 0);
    check("t1_ovr", ovr_err, 0);
    check("t1_drained", dq.size(), 0);

    // T2
    set_word(0, 8'h08, 3, 1'b1, 1'b0);
    burst(1, 1, -1);
    check("t2_viol_set", viol_err, 1);
    clear_errs();
    check("t2_viol_clr", viol_err, 0);

    // T3
    out_ready = 1'b0;
    set_word(0, 8'hFF, -1, 1'b1, 1'b0);
    set_word(1, 8'h01, -1, 1'b0, 1'b0);
    burst(2, P + 1, -1);
    check("t3_hold_data", out_data, 8'hFF);
    check("t3_hold_valid", out_valid, 1);
    check("t3_ovr", ovr_err, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_valid_drop", out_valid, 0);
    clear_errs();
    check("t3_ovr_clr", ovr_err, 0);

    // T4: run drops at bit 4; the second word's toggles arrive while idle
    set_word(0, 8'hFF, -1, 1'b1, 1'b0);
    set_word(1, $urandom_range(255, 1), -1, 1'b0, 1'b0);
    burst(2, 4 * SC + 1, -1);
    repeat (6) @(posedge clk); #1;
    check("t4_drained", dq.size(), 0);
    check("t4_idle_valid", out_valid, 0);

    // T5: reset at bit 5 of the second word while the first is still held
    out_ready = 1'b0;
    set_word(0, $urandom_range(255, 0), 2, 1'b0, 1'b0);
    set_word(1, $urandom_range(255, 0), -1, 1'b0, 1'b0);
    burst(2, 2 * P, P + 5 * SC + 1);
    check("t5_valid", out_valid, 0);
    check("t5_data", out_data, 0);
    check("t5_viol", viol_err, 0);
    check("t5_ovr", ovr_err, 0);
    out_ready = 1'b1;
    set_word(0, 8'h5A, -1, 1'b1, 1'b0);
    burst(1, 1, -1);
    check("t5_restart_drained", dq.size(), 0);

`ifdef SFQ_RX_PARITY_EN
    // T6
    set_word(0, 8'h03, -1, 1'b1, 1'b1);
    burst(1, 1, -1);
    check("t6_par_bad", par_err, 1);
    clear_errs();
    check("t6_par_clr", par_err, 0);
    set_word(0, 8'h03, -1, 1'b1, 1'b0);
    burst(1, 1, -1);
    check("t6_par_ok", par_err, 0);
`endif

    // Randomized back-to-back bursts
    for (int b = 0; b < 8; b++) begin
      nw = int'($urandom_range(4, 1));
      ev = 1'b0;
      ep = 1'b0;
      for (int w = 0; w < nw; w++) begin
        rd = W'($urandom);
        if ($urandom_range(3, 0) == 0) begin
          set_word(w, rd, int'($urandom_range(W - 1, 0)), 1'b1, 1'b0);
          ev = 1'b1;
        end else begin
          set_word(w, rd, -1, 1'b1, 1'b0);
        end
`ifdef SFQ_RX_PARITY_EN
        bw_pbad[w] = ($urandom_range(3, 0) == 0);
        ep = ep | bw_pbad[w];
`endif
      end
      burst(nw, (nw - 1) * P + 1, -1);
      check("rnd_drained", dq.size(), 0);
      check("rnd_viol", viol_err, ev);
      check("rnd_ovr", ovr_err, 0);
`ifdef SFQ_RX_PARITY_EN
      check("rnd_par", par_err, ep);
`endif
      clear_errs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
